// File: rtl/adder_share_arbiter_pkg.sv
// Shared FSM encoding and default sizing for the shared-adder arbiter.
package adder_share_arbiter_pkg;

    localparam int DEF_WIDTH   = 8;
    localparam int DEF_NUM_REQ = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/adder_share_arbiter_rca.sv
// Plain ripple-carry adder: WIDTH-bit unsigned add with carry in/out.
module ripple_carry_adder #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             c_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             c_o
);

    logic [WIDTH:0] carry;

    assign carry[0] = c_i;

    for (genvar g = 0; g < WIDTH; g++) begin : g_fa
        assign sum_o[g]   = a_i[g] ^ b_i[g] ^ carry[g];
        assign carry[g+1] = (a_i[g] & b_i[g]) | (carry[g] & (a_i[g] ^ b_i[g]));
    end

    assign c_o = carry[WIDTH];

endmodule

// File: rtl/adder_share_arbiter_rr_pick.sv
// Round-robin search: first valid requester after last_id_i, wrapping around.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [IDW-1:0]     last_id_i,
    output logic               found_o,
    output logic [IDW-1:0]     winner_o
);

    int idx;

    // Scan from the farthest offset down so the nearest valid one wins last.
    always_comb begin
        found_o  = 1'b0;
        winner_o = '0;
        idx      = 0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            idx = (int'(last_id_i) + i) % NUM_REQ;
            if (valid_i[idx]) begin
                found_o  = 1'b1;
                winner_o = idx[IDW-1:0];
            end
        end
    end

endmodule

// File: rtl/adder_share_arbiter.sv
// One ripple-carry adder shared round-robin among NUM_REQ requesters;
// results are tagged with the requester id and drained via valid/ready.
module adder_share_arbiter
    import adder_share_arbiter_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int NUM_REQ = DEF_NUM_REQ
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [NUM_REQ-1:0]         i_req_valid,
    output logic [NUM_REQ-1:0]         o_req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]   i_req_a,
    input  logic [NUM_REQ*WIDTH-1:0]   i_req_b,
    output logic                       o_res_valid,
    input  logic                       i_res_ready,
    output logic [WIDTH:0]             o_res_sum,
    output logic [$clog2(NUM_REQ)-1:0] o_res_id,
    output logic                       o_busy
);

    localparam int IDW = $clog2(NUM_REQ);

    state_e           state_q, state_d;
    logic [IDW-1:0]   last_id_q;
    logic [IDW-1:0]   id_q;
    logic [WIDTH-1:0] op_a_q, op_b_q;
    logic [WIDTH-1:0] op_a_d, op_b_d;
    logic [WIDTH:0]   res_sum_q;
    logic [IDW-1:0]   res_id_q;
    logic             res_valid_q;

    logic             found;
    logic [IDW-1:0]   winner;
    logic             grant_en;
    logic             grant;
    logic             handshake;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_pick (
        .valid_i   (i_req_valid),
        .last_id_i (last_id_q),
        .found_o   (found),
        .winner_o  (winner)
    );

    ripple_carry_adder #(
        .WIDTH (WIDTH)
    ) u_add (
        .a_i   (op_a_q),
        .b_i   (op_b_q),
        .c_i   (1'b0),
        .sum_o (add_sum),
        .c_o   (add_cout)
    );

    assign handshake = res_valid_q && i_res_ready;
    assign op_a_d    = i_req_a[winner*WIDTH +: WIDTH];
    assign op_b_d    = i_req_b[winner*WIDTH +: WIDTH];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (grant) state_d = ST_CALC;
            ST_CALC: state_d = ST_DONE;
            ST_DONE: if (handshake) state_d = grant ? ST_CALC : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Ready is gated by reset so nothing is accepted while rst_n is low.
    always_comb begin
        grant_en = 1'b0;
        unique case (state_q)
            ST_IDLE: grant_en = i_rst_n;
            ST_DONE: grant_en = i_rst_n && handshake;
            default: grant_en = 1'b0;
        endcase
        grant       = grant_en && found;
        o_req_ready = '0;
        if (grant) o_req_ready[winner] = 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            last_id_q   <= IDW'(NUM_REQ - 1);
            id_q        <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            res_sum_q   <= '0;
            res_id_q    <= '0;
            res_valid_q <= 1'b0;
        end else begin
            if (grant) begin
                op_a_q    <= op_a_d;
                op_b_q    <= op_b_d;
                id_q      <= winner;
                last_id_q <= winner;
            end
            if (state_q == ST_CALC) begin
                res_sum_q   <= {add_cout, add_sum};
                res_id_q    <= id_q;
                res_valid_q <= 1'b1;
            end else if (state_q == ST_DONE && handshake) begin
                res_valid_q <= 1'b0;
            end
        end
    end

    assign o_res_valid = res_valid_q;
    assign o_res_sum   = res_sum_q;
    assign o_res_id    = res_id_q;
    assign o_busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed bench for adder_share_arbiter with hand-computed expectations.
module tb_adder_share_arbiter;

    localparam int WIDTH   = 8;
    localparam int NUM_REQ = 4;
    localparam int IDW     = 2;

    logic                     i_clk = 1'b0;
    logic                     i_rst_n;
    logic [NUM_REQ-1:0]       i_req_valid;
    logic [NUM_REQ-1:0]       o_req_ready;
    logic [NUM_REQ*WIDTH-1:0] i_req_a;
    logic [NUM_REQ*WIDTH-1:0] i_req_b;
    logic                     o_res_valid;
    logic                     i_res_ready;
    logic [WIDTH:0]           o_res_sum;
    logic [IDW-1:0]           o_res_id;
    logic                     o_busy;

    int nvec = 0;
    int nerr = 0;

    adder_share_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_req_valid (i_req_valid),
        .o_req_ready (o_req_ready),
        .i_req_a     (i_req_a),
        .i_req_b     (i_req_b),
        .o_res_valid (o_res_valid),
        .i_res_ready (i_res_ready),
        .o_res_sum   (o_res_sum),
        .o_res_id    (o_res_id),
        .o_busy      (o_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic [7:0] a, input logic [7:0] b, input logic v);
        i_req_a[k*WIDTH +: WIDTH] = a;
        i_req_b[k*WIDTH +: WIDTH] = b;
        i_req_valid[k]            = v;
    endtask

    // One isolated transaction with the consumer always ready.
    task automatic one_shot(input string tag, input int k, input logic [7:0] a,
                            input logic [7:0] b, input logic [8:0] exp_sum);
        set_req(k, a, b, 1'b1);
        i_res_ready = 1'b1;
        #1;
        chk({tag, "_ready"}, o_req_ready, 32'(1 << k));
        tick();
        i_req_valid = '0;
        chk({tag, "_calc_valid"}, o_res_valid, 0);
        chk({tag, "_calc_busy"}, o_busy, 1);
        tick();
        chk({tag, "_valid"}, o_res_valid, 1);
        chk({tag, "_sum"}, o_res_sum, exp_sum);
        chk({tag, "_id"}, o_res_id, k);
        tick();
        chk({tag, "_idle_valid"}, o_res_valid, 0);
        chk({tag, "_idle_busy"}, o_busy, 0);
    endtask

    task automatic do_reset();
        i_rst_n     = 1'b0;
        i_req_valid = '0;
        i_res_ready = 1'b0;
        tick();
        tick();
        i_rst_n = 1'b1;
        tick();
    endtask

    logic [7:0] rr_a [4];
    logic [7:0] rr_b [4];
    logic [8:0] rr_s [4];

    initial begin
        i_rst_n     = 1'b0;
        i_req_valid = 4'b0001;
        i_req_a     = '0;
        i_req_b     = '0;
        i_res_ready = 1'b1;
        tick();
        chk("rst_ready", o_req_ready, 0);
        chk("rst_valid", o_res_valid, 0);
        chk("rst_sum", o_res_sum, 0);
        chk("rst_id", o_res_id, 0);
        chk("rst_busy", o_busy, 0);
        do_reset();

        one_shot("single", 0, 8'h12, 8'h34, 9'h046);
        one_shot("ovf_ff01", 0, 8'hFF, 8'h01, 9'h100);
        one_shot("ovf_8080", 1, 8'h80, 8'h80, 9'h100);

        // Round-robin with all four requesters continuously valid.
        do_reset();
        rr_a = '{8'hF0, 8'h01, 8'h7F, 8'hAA};
        rr_b = '{8'h20, 8'h02, 8'h81, 8'h55};
        rr_s = '{9'h110, 9'h003, 9'h100, 9'h0FF};
        for (int k = 0; k < 4; k++) set_req(k, rr_a[k], rr_b[k], 1'b1);
        i_res_ready = 1'b1;
        #1;
        for (int g = 0; g < 5; g++) begin
            chk($sformatf("rr_grant%0d", g), o_req_ready, 32'(1 << (g % 4)));
            if (g > 0) begin
                chk($sformatf("rr_valid%0d", g - 1), o_res_valid, 1);
                chk($sformatf("rr_sum%0d", g - 1), o_res_sum, rr_s[(g - 1) % 4]);
                chk($sformatf("rr_id%0d", g - 1), o_res_id, (g - 1) % 4);
            end
            tick();
            chk($sformatf("rr_calc_ready%0d", g), o_req_ready, 0);
            chk($sformatf("rr_calc_valid%0d", g), o_res_valid, 0);
            tick();
        end
        chk("rr_last_sum", o_res_sum, 9'h110);
        chk("rr_last_id", o_res_id, 0);
        i_req_valid = '0;
        #1;
        chk("rr_drain_ready", o_req_ready, 0);
        tick();
        chk("rr_idle_busy", o_busy, 0);

        // Backpressure: last winner was 0, so requester 2 is next.
        set_req(2, 8'h33, 8'h44, 1'b1);
        i_res_ready = 1'b0;
        #1;
        chk("bp_ready", o_req_ready, 32'b0100);
        tick();
        i_req_valid = '0;
        tick();
        set_req(3, 8'h05, 8'h06, 1'b1);
        for (int c = 0; c < 5; c++) begin
            #1;
            chk($sformatf("bp_hold_ready%0d", c), o_req_ready, 0);
            chk($sformatf("bp_hold_valid%0d", c), o_res_valid, 1);
            chk($sformatf("bp_hold_sum%0d", c), o_res_sum, 9'h077);
            chk($sformatf("bp_hold_id%0d", c), o_res_id, 2);
            tick();
        end
        i_res_ready = 1'b1;
        #1;
        chk("bp_b2b_ready", o_req_ready, 32'b1000);
        tick();
        i_req_valid = '0;
        chk("bp_calc_valid", o_res_valid, 0);
        tick();
        chk("bp_res_sum", o_res_sum, 9'h00B);
        chk("bp_res_id", o_res_id, 3);
        tick();
        chk("bp_idle_busy", o_busy, 0);

        // Reset while holding an undelivered result in DONE.
        set_req(1, 8'h10, 8'h20, 1'b1);
        i_res_ready = 1'b0;
        #1;
        chk("rm_ready", o_req_ready, 32'b0010);
        tick();
        i_req_valid = '0;
        tick();
        chk("rm_done_valid", o_res_valid, 1);
        i_rst_n = 1'b0;
        #1;
        chk("rm_valid", o_res_valid, 0);
        chk("rm_busy", o_busy, 0);
        chk("rm_sum", o_res_sum, 0);
        tick();
        i_rst_n = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) set_req(k, 8'h01, 8'h02, 1'b1);
        i_res_ready = 1'b1;
        #1;
        chk("rm_first_grant", o_req_ready, 32'b0001);
        tick();
        i_req_valid = '0;
        tick();
        chk("rm_res_id", o_res_id, 0);
        chk("rm_res_sum", o_res_sum, 9'h003);
        tick();

        // Requester 2 pulses valid only during CALC and must be ignored.
        set_req(0, 8'h0A, 8'h0B, 1'b1);
        #1;
        chk("dv_ready0", o_req_ready, 32'b0001);
        tick();
        i_req_valid = 4'b0100;
        #1;
        chk("dv_calc_ready", o_req_ready, 0);
        tick();
        i_req_valid = '0;
        #1;
        chk("dv_done_ready", o_req_ready, 0);
        chk("dv_done_sum", o_res_sum, 9'h015);
        tick();
        chk("dv_idle_busy", o_busy, 0);
        chk("dv_idle_valid", o_res_valid, 0);
        tick();
        chk("dv_still_idle", o_busy, 0);
        chk("dv_no_grant", o_req_ready, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
